// File: rtl/csr_access_unit_pkg.sv
// Shared CSR definitions: address map, instruction op encoding and access-unit states.
// Imported by the access unit, the CSR file and decode.
package csr_access_unit_pkg;

  localparam logic [11:0] CSR_STATUS   = 12'h000;
  localparam logic [11:0] CSR_FSTATUS  = 12'h001;
  localparam logic [11:0] CSR_VSTATUS  = 12'h002;
  localparam logic [11:0] CSR_CONFIG   = 12'h003;
  localparam logic [11:0] CSR_CORE_ID  = 12'hC00;
  localparam logic [11:0] CSR_TILE_OFF = 12'hC01;

  typedef enum logic [1:0] {
    CSR_OP_RW  = 2'd0,
    CSR_OP_RS  = 2'd1,
    CSR_OP_RC  = 2'd2,
    CSR_OP_RSV = 2'd3
  } csr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_ACCESS,
    ST_RC_WR,
    ST_RESP
  } csr_state_e;

  // The top two address bits mark the read-only CSR window.
  function automatic logic is_read_only(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

  function automatic logic has_write_intent(input csr_op_e op, input logic src_zero);
    return (op == CSR_OP_RW) || !src_zero;
  endfunction

endpackage

// File: rtl/csr_access_unit.sv
// Initiator side of the CSR port: drains in-flight FP/vector work, performs the access
// (emulating CSRRC as read + masked write) and returns the old value via writeback.
module csr_access_unit
  import csr_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic        req_imm,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_rs1_data,
  input  logic [4:0]  req_uimm,
  input  logic        req_src_zero,
  input  logic [4:0]  req_rd,
  input  logic        pipe_busy,
  output logic        csr_busy,
  output logic        csr_en,
  output logic        csr_csrrs,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err_illegal
);

  csr_state_e  state_reg;
  csr_op_e     op_reg;
  logic [11:0] addr_reg;
  logic [4:0]  rd_reg;
  logic        src_zero_reg;
  logic [31:0] mask_reg;
  logic [31:0] old_reg;

  logic intent;
  logic read_only;
  logic write_ok;
  logic in_access;
  logic in_rc_wr;

  assign intent    = has_write_intent(op_reg, src_zero_reg);
  assign read_only = is_read_only(addr_reg);
  assign write_ok  = intent && !read_only;
  assign in_access = (state_reg == ST_ACCESS);
  assign in_rc_wr  = (state_reg == ST_RC_WR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      op_reg       <= CSR_OP_RW;
      addr_reg     <= '0;
      rd_reg       <= '0;
      src_zero_reg <= 1'b0;
      mask_reg     <= '0;
      old_reg      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            // The reserved encoding behaves as set-bits so only RW/RS/RC are ever stored.
            op_reg       <= (req_op == CSR_OP_RSV) ? CSR_OP_RS : csr_op_e'(req_op);
            addr_reg     <= req_addr;
            rd_reg       <= req_rd;
            src_zero_reg <= req_src_zero;
            mask_reg     <= req_imm ? {27'b0, req_uimm} : req_rs1_data;
            state_reg    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!pipe_busy) state_reg <= ST_ACCESS;
        end
        ST_ACCESS: begin
          old_reg <= csr_rdata;
          if (op_reg == CSR_OP_RC && write_ok) state_reg <= ST_RC_WR;
          else if (rd_reg == 5'd0)             state_reg <= ST_IDLE;
          else                                 state_reg <= ST_RESP;
        end
        ST_RC_WR: begin
          state_reg <= (rd_reg == 5'd0) ? ST_IDLE : ST_RESP;
        end
        ST_RESP: begin
          if (wb_ready) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Port strobes decode only from registered state so nothing glitches off req_* inputs.
  always_comb begin
    csr_en    = 1'b0;
    csr_csrrs = 1'b0;
    csr_addr  = '0;
    csr_wdata = '0;
    if (in_access) begin
      csr_addr = addr_reg;
      if (write_ok && op_reg != CSR_OP_RC) begin
        csr_en    = 1'b1;
        csr_csrrs = (op_reg == CSR_OP_RS);
        csr_wdata = mask_reg;
      end
    end else if (in_rc_wr) begin
      csr_addr  = addr_reg;
      csr_en    = 1'b1;
      csr_wdata = old_reg & ~mask_reg;
    end
  end

  assign req_ready   = (state_reg == ST_IDLE);
  assign csr_busy    = (state_reg != ST_IDLE);
  assign err_illegal = in_access && intent && read_only;
  assign wb_valid    = (state_reg == ST_RESP);
  assign wb_rd       = wb_valid ? rd_reg : 5'd0;
  assign wb_data     = wb_valid ? old_reg : 32'd0;

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: a cycle schedule is derived from the instruction-level rules
// and a CSR-file model, then played against the DUT and compared every cycle.
module tb_csr_access_unit;
  import csr_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic        req_imm = 1'b0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_rs1_data = '0;
  logic [4:0]  req_uimm = '0;
  logic        req_src_zero = 1'b0;
  logic [4:0]  req_rd = '0;
  logic        pipe_busy = 1'b0;
  logic        csr_busy;
  logic        csr_en;
  logic        csr_csrrs;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_illegal;

  csr_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_imm(req_imm),
    .req_addr(req_addr), .req_rs1_data(req_rs1_data), .req_uimm(req_uimm),
    .req_src_zero(req_src_zero), .req_rd(req_rd), .pipe_busy(pipe_busy),
    .csr_busy(csr_busy), .csr_en(csr_en), .csr_csrrs(csr_csrrs), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req_valid;
    logic [1:0]  op;
    logic        imm;
    logic [11:0] addr;
    logic [31:0] rs1;
    logic [4:0]  uimm;
    logic        src_zero;
    logic [4:0]  rd;
    logic        pipe_busy;
    logic        wb_ready;
    logic        inj;
    logic        e_ready;
    logic        e_busy;
    logic        e_en;
    logic        e_rs;
    logic        e_err;
    logic        e_wbv;
    logic        e_wdata_chk;
    logic [11:0] e_addr;
    logic [31:0] e_wdata;
    logic [4:0]  e_rd;
    logic [31:0] e_wbdata;
  } cyc_t;

  cyc_t sched[$];
  cyc_t cur;
  logic cur_valid = 1'b0;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  logic [31:0] wb_last = '0;

  // CSR file environment: combinational read, write/set on csr_en, sticky error injection.
  logic [31:0] env_csr [0:4095];
  logic        env_ready = 1'b0;
  assign csr_rdata = env_csr[csr_addr];

  always @(posedge clk) begin
    if (!env_ready) begin
      env_csr[CSR_STATUS]   <= 32'h0000_000F;
      env_csr[CSR_FSTATUS]  <= 32'h0000_0015;
      env_csr[CSR_VSTATUS]  <= 32'h0000_0000;
      env_csr[CSR_CONFIG]   <= 32'h0000_0000;
      env_csr[CSR_CORE_ID]  <= 32'h0000_0007;
      env_csr[CSR_TILE_OFF] <= 32'h0000_0100;
      env_ready <= 1'b1;
    end else begin
      if (csr_en)
        env_csr[csr_addr] <= csr_csrrs ? (env_csr[csr_addr] | csr_wdata) : csr_wdata;
      if (cur_valid && cur.inj)
        env_csr[CSR_VSTATUS] <= env_csr[CSR_VSTATUS] | 32'h1;
    end
  end

  // Reference CSR contents, advanced by the instruction-level rules.
  logic [31:0] golden [0:4095];
  logic [11:0] addrs [0:5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cur_valid) begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, cur.e_ready});
      chk("csr_busy", {31'b0, csr_busy}, {31'b0, cur.e_busy});
      chk("csr_en", {31'b0, csr_en}, {31'b0, cur.e_en});
      chk("csr_csrrs", {31'b0, csr_csrrs}, {31'b0, cur.e_rs});
      chk("csr_addr", {20'b0, csr_addr}, {20'b0, cur.e_addr});
      if (cur.e_wdata_chk) chk("csr_wdata", csr_wdata, cur.e_wdata);
      chk("err_illegal", {31'b0, err_illegal}, {31'b0, cur.e_err});
      chk("wb_valid", {31'b0, wb_valid}, {31'b0, cur.e_wbv});
      if (cur.e_wbv) begin
        chk("wb_rd", {27'b0, wb_rd}, {27'b0, cur.e_rd});
        chk("wb_data", wb_data, cur.e_wbdata);
      end
      if (wb_valid && wb_ready) wb_last = wb_data;
      if (err_illegal) err_seen++;
    end
  end

  function automatic cyc_t base_rec(input logic idle);
    cyc_t r;
    r = '0;
    r.e_ready = idle;
    r.e_busy = !idle;
    r.e_wdata_chk = 1'b1;
    // Irrelevant inputs carry noise so the DUT must rely on its latched copies.
    r.rs1 = $urandom;
    r.addr = 12'($urandom);
    r.pipe_busy = idle ? 1'b0 : 1'($urandom);
    r.wb_ready = 1'($urandom);
    r.req_valid = idle ? 1'b0 : 1'($urandom);
    return r;
  endfunction

  task automatic add_txn(input logic [1:0] op, input logic imm, input logic [11:0] addr,
                         input logic [31:0] rs1, input logic [4:0] uimm, input logic src_zero,
                         input logic [4:0] rd, input int nbusy, input int nstall, input logic inject);
    cyc_t r;
    logic [31:0] mask, old_val;
    logic intent, ro, rc_write;
    logic [1:0] opn;
    opn = (op == 2'd3) ? 2'd1 : op;
    mask = imm ? {27'b0, uimm} : rs1;
    intent = (opn == 2'd0) || !src_zero;
    ro = (addr[11:10] == 2'b11);
    rc_write = 1'b0;

    r = base_rec(1'b1);
    r.req_valid = 1'b1; r.op = op; r.imm = imm; r.addr = addr; r.rs1 = rs1;
    r.uimm = uimm; r.src_zero = src_zero; r.rd = rd;
    sched.push_back(r);

    for (int i = 0; i <= nbusy; i++) begin
      r = base_rec(1'b0);
      r.pipe_busy = (i < nbusy);
      r.inj = inject && (i == 0) && (nbusy > 0);
      sched.push_back(r);
    end
    if (inject && nbusy > 0) golden[CSR_VSTATUS] = golden[CSR_VSTATUS] | 32'h1;

    old_val = golden[addr];
    r = base_rec(1'b0);
    r.e_addr = addr;
    r.e_err = intent && ro;
    r.e_wdata_chk = 1'b0;
    if (intent && !ro) begin
      if (opn == 2'd0) begin
        r.e_en = 1'b1; r.e_wdata = mask; r.e_wdata_chk = 1'b1;
        golden[addr] = mask;
      end else if (opn == 2'd1) begin
        r.e_en = 1'b1; r.e_rs = 1'b1; r.e_wdata = mask; r.e_wdata_chk = 1'b1;
        golden[addr] = old_val | mask;
      end else begin
        rc_write = 1'b1;
      end
    end
    sched.push_back(r);

    if (rc_write) begin
      r = base_rec(1'b0);
      r.e_addr = addr; r.e_en = 1'b1; r.e_wdata = old_val & ~mask;
      golden[addr] = old_val & ~mask;
      sched.push_back(r);
    end

    if (rd != 5'd0) begin
      for (int i = 0; i <= nstall; i++) begin
        r = base_rec(1'b0);
        r.wb_ready = (i == nstall);
        r.e_wbv = 1'b1; r.e_rd = rd; r.e_wbdata = old_val;
        sched.push_back(r);
      end
    end
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) sched.push_back(base_rec(1'b1));
  endtask

  task automatic play();
    while (sched.size() > 0) begin
      cur = sched.pop_front();
      req_valid = cur.req_valid; req_op = cur.op; req_imm = cur.imm; req_addr = cur.addr;
      req_rs1_data = cur.rs1; req_uimm = cur.uimm; req_src_zero = cur.src_zero;
      req_rd = cur.rd; pipe_busy = cur.pipe_busy; wb_ready = cur.wb_ready;
      cur_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    cur_valid = 1'b0;
    req_valid = 1'b0;
    pipe_busy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic        imm, sz;
    logic [31:0] rs1;
    logic [4:0]  uimm, rd;
    logic [11:0] a;

    addrs[0] = CSR_STATUS;  addrs[1] = CSR_FSTATUS; addrs[2] = CSR_VSTATUS;
    addrs[3] = CSR_CONFIG;  addrs[4] = CSR_CORE_ID; addrs[5] = CSR_TILE_OFF;
    golden[CSR_STATUS] = 32'h0000_000F;  golden[CSR_FSTATUS] = 32'h0000_0015;
    golden[CSR_VSTATUS] = 32'h0;         golden[CSR_CONFIG] = 32'h0;
    golden[CSR_CORE_ID] = 32'h0000_0007; golden[CSR_TILE_OFF] = 32'h0000_0100;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_csr_busy", {31'b0, csr_busy}, 32'd0);
    chk("rst_csr_en", {31'b0, csr_en}, 32'd0);
    chk("rst_csr_csrrs", {31'b0, csr_csrrs}, 32'd0);
    chk("rst_csr_addr", {20'b0, csr_addr}, 32'd0);
    chk("rst_csr_wdata", csr_wdata, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_err_illegal", {31'b0, err_illegal}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    add_txn(2'd0, 1'b0, CSR_CONFIG, 32'hDEADBEEF, 5'd0, 1'b0, 5'd5, 0, 0, 1'b0);
    play();
    chk("dir_rw_wb", wb_last, 32'h0);
    chk("dir_rw_config", env_csr[CSR_CONFIG], 32'hDEADBEEF);

    add_txn(2'd2, 1'b0, CSR_STATUS, 32'h3, 5'd0, 1'b0, 5'd9, 0, 0, 1'b0);
    play();
    chk("dir_rc_wb", wb_last, 32'hF);
    chk("dir_rc_status", env_csr[CSR_STATUS], 32'hC);

    add_txn(2'd1, 1'b1, CSR_FSTATUS, 32'h0, 5'd0, 1'b1, 5'd2, 0, 0, 1'b0);
    play();
    chk("dir_rs_imm0_wb", wb_last, 32'h15);

    add_txn(2'd1, 1'b0, CSR_VSTATUS, 32'h0, 5'd0, 1'b1, 5'd4, 4, 0, 1'b1);
    play();
    chk("dir_drain_sticky_wb", wb_last, 32'h1);

    err_seen = 0;
    add_txn(2'd0, 1'b0, CSR_CORE_ID, 32'h5, 5'd0, 1'b0, 5'd3, 0, 0, 1'b0);
    play();
    chk("dir_ro_err_count", err_seen, 32'd1);
    chk("dir_ro_wb", wb_last, 32'h7);

    add_txn(2'd1, 1'b0, CSR_STATUS, 32'h30, 5'd0, 1'b0, 5'd7, 0, 3, 1'b0);
    add_txn(2'd2, 1'b0, CSR_CONFIG, 32'hFF, 5'd0, 1'b0, 5'd0, 1, 0, 1'b0);
    add_idle(1);
    play();
    chk("dir_stall_wb", wb_last, 32'hC);
    chk("dir_rc_rd0_config", env_csr[CSR_CONFIG], 32'hDEADBE00);

    for (int n = 0; n < 60; n++) begin
      op   = 2'($urandom);
      imm  = 1'($urandom);
      a    = addrs[$urandom_range(0, 5)];
      uimm = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rs1  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      sz   = imm ? (uimm == 5'd0) : ((rs1 == 32'd0) && 1'($urandom));
      rd   = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      add_txn(op, imm, a, rs1, uimm, sz, rd, $urandom_range(0, 3), $urandom_range(0, 2),
              1'($urandom));
      add_idle($urandom_range(0, 1));
    end
    play();

    add_txn(2'd0, 1'b0, CSR_STATUS, 32'hA5A5_A5A5, 5'd0, 1'b0, 5'd1, 0, 0, 1'b0);
    play();
    // Reset arrives while the masked RC write is on the port: it must never land.
    req_valid = 1'b1; req_op = 2'd2; req_imm = 1'b0; req_addr = CSR_STATUS;
    req_rs1_data = 32'hFFFF_FFFF; req_src_zero = 1'b0; req_rd = 5'd6; pipe_busy = 1'b0;
    wb_ready = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rcwr_en_before_reset", {31'b0, csr_en}, 32'd1);
    chk("rcwr_wdata_before_reset", csr_wdata, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rcwr_en_in_reset", {31'b0, csr_en}, 32'd0);
    @(negedge clk);
    chk("rcwr_ready_in_reset", {31'b0, req_ready}, 32'd1);
    chk("rcwr_busy_in_reset", {31'b0, csr_busy}, 32'd0);
    chk("rcwr_wbv_in_reset", {31'b0, wb_valid}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rcwr_status_kept", env_csr[CSR_STATUS], 32'hA5A5_A5A5);
    chk("rcwr_idle_after", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < 6; i++)
      chk("final_csr", env_csr[addrs[i]], golden[addrs[i]]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
